// File: rtl/misc_v_pkg.sv
// Shared pipeline definitions: data width, MEM-stage FSM states and the
// EX/MEM latch layout.
package misc_v_pkg;

  localparam int unsigned XLEN = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] rd;
  } exmem_t;

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit wait-cycle counter for the MEM stage; tc_o flags that the count has
// reached TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == 8'(TIMEOUT));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM latch, single-request data-memory handshake with
// timeout abort, and combinational hand-off to the MEM/WB register.
module mem_access_stage
  import misc_v_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_reg_store,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_load_data,
  output logic [XLEN-1:0] wb_rd,
  output logic            mem_err
);

  mem_state_e state_q, state_d;
  exmem_t     lat_q, lat_d;
  logic       tc, in_wait, ack_hit, abort, hold, capture, new_mem;

  assign in_wait = (state_q == ST_WAIT);
  assign ack_hit = in_wait && dmem_ack;
  // Ack wins over the timeout if both land in the same cycle.
  assign abort   = in_wait && tc && !dmem_ack;
  assign hold    = in_wait && !dmem_ack && !tc;
  assign capture = !hold;

  always_comb begin
    lat_d.valid      = ex_valid && !flush;
    lat_d.reg_write  = ex_reg_write;
    lat_d.mem_read   = ex_mem_read;
    lat_d.mem_write  = ex_mem_write;
    lat_d.alu_result = ex_alu_result;
    lat_d.store_data = ex_store_data;
    lat_d.rd         = ex_rd;
    new_mem          = lat_d.valid && (ex_mem_read || ex_mem_write);
    state_d          = new_mem ? ST_WAIT : ST_IDLE;
  end

  // Completing or aborting a request frees the stage, so the next EX op is
  // captured on the same edge and may itself start a new request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else if (capture) begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (capture && new_mem),
    .enable_i(hold),
    .tc_o    (tc)
  );

  always_comb begin
    stall         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    wb_valid      = 1'b0;
    wb_reg_write  = 1'b0;
    wb_reg_store  = 1'b0;
    wb_alu_result = '0;
    wb_load_data  = '0;
    wb_rd         = '0;
    mem_err       = 1'b0;
    if (!reset) begin
      wb_alu_result = lat_q.alu_result;
      wb_rd         = lat_q.rd;
      wb_reg_write  = lat_q.reg_write;
      if (!in_wait) begin
        wb_valid = lat_q.valid;
      end else if (abort) begin
        mem_err      = 1'b1;
        wb_valid     = 1'b1;
        wb_reg_write = 1'b0;
      end else begin
        dmem_req   = 1'b1;
        dmem_we    = lat_q.mem_write;
        dmem_addr  = lat_q.alu_result;
        dmem_wdata = lat_q.store_data;
        if (ack_hit) begin
          wb_valid     = 1'b1;
          wb_load_data = dmem_rdata;
          wb_reg_store = lat_q.mem_read && !lat_q.mem_write;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 15;
  localparam int unsigned N_OPS = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, flush;
  logic [15:0] ex_alu_result, ex_store_data, ex_rd;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_reg_store, mem_err;
  logic [15:0] wb_alu_result, wb_load_data, wb_rd;

  mem_access_stage #(
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_reg_store (wb_reg_store),
    .wb_alu_result(wb_alu_result),
    .wb_load_data (wb_load_data),
    .wb_rd        (wb_rd),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  typedef struct {
    bit          valid;
    bit          rw;
    bit          mr;
    bit          mw;
    bit          flush;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [15:0] rdst;
    logic [15:0] rdata;
    int unsigned delay;  // cycles before ack; > TO means never acked in time
  } op_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(bit v, bit rw, bit mr, bit mw, logic [15:0] alu, logic [15:0] sd,
                             logic [15:0] rdst, logic [15:0] rdata, int unsigned dly);
    op_t o;
    o.valid = v;  o.rw = rw;  o.mr = mr;  o.mw = mw;  o.flush = 1'b0;
    o.alu = alu;  o.sd = sd;  o.rdst = rdst;  o.rdata = rdata;  o.delay = dly;
    return o;
  endfunction

  function automatic op_t directed(int unsigned i);
    case (i)
      0:       return mk(1, 1, 0, 0, 16'h1234, 16'h0000, 16'd3, 16'h0000, 0);
      1:       return mk(1, 1, 1, 0, 16'h0040, 16'h0000, 16'd5, 16'hBEEF, 3);
      2:       return mk(1, 0, 0, 1, 16'h0010, 16'h5A5A, 16'd0, 16'h0000, 0);
      3:       return mk(1, 1, 0, 0, 16'h00AA, 16'h0000, 16'd7, 16'h0000, 0);
      4:       return mk(1, 1, 1, 0, 16'h0100, 16'h0000, 16'd2, 16'h0000, 255);
      default: return mk(1, 1, 0, 0, 16'h0BAD, 16'h0000, 16'd1, 16'h0000, 0);
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int unsigned kind;
    kind    = $urandom_range(0, 3);
    o.valid = ($urandom_range(0, 9) != 0);
    o.flush = ($urandom_range(0, 7) == 0);
    o.rw    = 1'($urandom_range(0, 1));
    o.mr    = (kind == 1) || (kind == 3);
    o.mw    = (kind == 2) || (kind == 3);
    o.alu   = 16'($urandom);
    o.sd    = 16'($urandom);
    o.rdst  = 16'($urandom);
    o.rdata = 16'($urandom);
    o.delay = ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 5);
    return o;
  endfunction

  function automatic bit eff_valid(op_t o);
    return o.valid && !o.flush;
  endfunction

  function automatic bit is_mem(op_t o);
    return eff_valid(o) && (o.mr || o.mw);
  endfunction

  task automatic drive_ex(input op_t o);
    ex_valid = o.valid;  ex_reg_write = o.rw;  ex_mem_read = o.mr;  ex_mem_write = o.mw;
    ex_alu_result = o.alu;  ex_store_data = o.sd;  ex_rd = o.rdst;  flush = o.flush;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_req"}, dmem_req, 0);
    check_eq({tag, "_we"}, dmem_we, 0);
    check_eq({tag, "_addr"}, dmem_addr, 0);
    check_eq({tag, "_wb_valid"}, wb_valid, 0);
    check_eq({tag, "_wb_alu"}, wb_alu_result, 0);
    check_eq({tag, "_wb_rd"}, wb_rd, 0);
    check_eq({tag, "_mem_err"}, mem_err, 0);
  endtask

  op_t         prev, cur, idle_op;
  int unsigned n_stall;
  bit          acked;

  initial begin
    idle_op = mk(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    reset = 1'b1;
    drive_ex(idle_op);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    @(negedge clk);
    #1 check_all_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1 check_all_zero("post_reset");
    @(posedge clk);
    @(negedge clk);

    prev = idle_op;
    for (int unsigned i = 0; i <= N_OPS; i++) begin
      if (i == N_OPS)  cur = idle_op;
      else if (i < 6)  cur = directed(i);
      else             cur = rand_op();

      if (is_mem(prev)) begin
        acked   = (prev.delay <= TO);
        n_stall = acked ? prev.delay : TO;
        for (int unsigned k = 0; k < n_stall; k++) begin
          // Junk on the EX side (flush included) must not disturb the held op.
          drive_ex(rand_op());
          dmem_ack = 1'b0;
          dmem_rdata = 16'($urandom);
          #1;
          check_eq("wait_stall", stall, 1);
          check_eq("wait_wb_valid", wb_valid, 0);
          check_eq("wait_req", dmem_req, 1);
          check_eq("wait_addr", dmem_addr, prev.alu);
          check_eq("wait_wdata", dmem_wdata, prev.sd);
          check_eq("wait_we", dmem_we, prev.mw);
          check_eq("wait_err", mem_err, 0);
          @(posedge clk);
          @(negedge clk);
        end
        drive_ex(cur);
        dmem_ack = acked;
        dmem_rdata = prev.rdata;
        #1;
        check_eq("done_stall", stall, 0);
        check_eq("done_wb_valid", wb_valid, 1);
        check_eq("done_mem_err", mem_err, !acked);
        check_eq("done_req", dmem_req, acked);
        check_eq("done_we", dmem_we, acked && prev.mw);
        check_eq("done_wdata", dmem_wdata, acked ? prev.sd : 16'h0);
        check_eq("done_reg_write", wb_reg_write, acked && prev.rw);
        check_eq("done_reg_store", wb_reg_store, acked && prev.mr && !prev.mw);
        check_eq("done_load_data", wb_load_data, acked ? prev.rdata : 16'h0);
        check_eq("done_alu", wb_alu_result, prev.alu);
        check_eq("done_rd", wb_rd, prev.rdst);
      end else begin
        drive_ex(cur);
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = 16'($urandom);
        #1;
        check_eq("idle_stall", stall, 0);
        check_eq("idle_req", dmem_req, 0);
        check_eq("idle_err", mem_err, 0);
        check_eq("idle_wb_valid", wb_valid, eff_valid(prev));
        if (eff_valid(prev)) begin
          check_eq("alu_wb_alu", wb_alu_result, prev.alu);
          check_eq("alu_wb_rd", wb_rd, prev.rdst);
          check_eq("alu_reg_write", wb_reg_write, prev.rw);
          check_eq("alu_reg_store", wb_reg_store, 0);
          check_eq("alu_load_data", wb_load_data, 0);
        end
      end
      @(posedge clk);
      @(negedge clk);
      prev = cur;
    end

    // Reset while a load is outstanding: request dropped, no error pulse.
    drive_ex(mk(1, 1, 1, 0, 16'h0077, 16'h0, 16'd4, 16'h0, 0));
    dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_ex(idle_op);
    #1 check_eq("rst_wait_stall", stall, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check_all_zero("rst_in_wait");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_all_zero("rst_after_wait");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, 15, max WAIT cycles without dmem_ack before abort (range 1..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  EX result valid this cycle.
REQ-005 ex_reg_write  in  1  instruction writes register file.
REQ-006 ex_mem_read  in  1  load instruction.
REQ-007 ex_mem_write  in  1  store instruction.
REQ-008 ex_alu_result  in  16  ALU result / memory word address.
REQ-009 ex_store_data  in  16  store data.
REQ-010 ex_rd  in  16  destination register field.
REQ-011 flush  in  1  discard op presented by EX.
REQ-012 stall  out  1  hold EX and earlier stages.
REQ-013 dmem_req, dmem_we  out  1 each  memory request, write enable.
REQ-014 dmem_addr, dmem_wdata  out  16 each  address, write data.
REQ-015 dmem_rdata  in  16  read data, valid with dmem_ack.
REQ-016 dmem_ack  in  1  single-cycle request completion.
REQ-017 wb_valid, wb_reg_write, wb_reg_store  out  1 each  to MEM/WB register; wb_reg_store=1 selects load data.
REQ-018 wb_alu_result, wb_load_data, wb_rd  out  16 each  to MEM/WB register.
REQ-019 mem_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-020 Internal EX/MEM latch SHALL capture ex_* on rising edge when stall=0; latch valid = ex_valid & ~flush.
REQ-021 While stall=1 the latch SHALL hold; flush SHALL be ignored while stall=1.
REQ-022 FSM states SHALL be IDLE and WAIT.
REQ-023 IDLE -> WAIT SHALL occur on the edge capturing a valid op with ex_mem_read or ex_mem_write set.
REQ-024 In IDLE, wb_* SHALL reflect the latch combinationally: wb_valid=latch valid, wb_reg_store=0, wb_load_data=0.
REQ-025 In WAIT, dmem_req=1, dmem_addr=latched alu_result, dmem_wdata=latched store_data, dmem_we=latched mem_write; all SHALL be stable until ack or abort.
REQ-026 When both mem_read and mem_write are set, write SHALL take priority (dmem_we=1, wb_reg_store=0).
REQ-027 In WAIT without ack: stall=1, wb_valid=0.
REQ-028 In WAIT with dmem_ack: stall=0, wb_valid=1, wb_load_data=dmem_rdata, wb_reg_store=latched mem_read & ~mem_write, next state IDLE; a new EX op SHALL be captured at that edge (zero bubble).
REQ-029 Wait counter (8-bit) SHALL clear on entering WAIT and increment each WAIT cycle without ack.
REQ-030 When counter reaches TIMEOUT with no ack: dmem_req=0, stall=0, mem_err=1, wb_valid=1 with wb_reg_write=0 (squashed), next state IDLE.
REQ-031 dmem_ack outside WAIT SHALL be ignored.
REQ-032 stall SHALL be 0 whenever state is IDLE.

Reset
REQ-033 reset SHALL force state IDLE, latch valid=0, all latch fields 0, counter 0.
REQ-034 During and one cycle after reset all outputs SHALL be 0 (stall, dmem_req, wb_valid, mem_err included).
REQ-035 reset in WAIT SHALL abandon the request with no mem_err pulse.

Structure
REQ-036 XLEN=16 and the IDLE/WAIT state enum SHALL live in shared package misc_v_pkg.
REQ-037 Timeout counter SHALL be sub-module mem_wait_timer (clear, enable, terminal-count out).

Verification
REQ-038 ALU op alu_result=0x1234, rd=3, reg_write=1 -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=3, stall=0, dmem_req=0.
REQ-039 Load addr 0x0040, ack after 3 cycles with rdata=0xBEEF -> stall=1 for 3 cycles, then wb_valid=1, wb_load_data=0xBEEF, wb_reg_store=1.
REQ-040 Store addr 0x0010 data 0x5A5A, immediate ack -> dmem_we=1, dmem_wdata=0x5A5A for one cycle, no stall, following op captured next edge.
REQ-041 Load never acked, TIMEOUT=15 -> stall for 15 cycles, then mem_err pulse, wb_valid=1, wb_reg_write=0, state IDLE.
REQ-042 reset asserted during WAIT and flush asserted during stall -> reset yields all-zero outputs without mem_err; flush leaves latched op unchanged.
